multi_cycle_control_fsm: RTL and testbench

- Main control unit for the multicycle processor variant.
- Decodes op/funct of the latched instruction and sequences each instruction through FETCH → DECODE → execute/memory/writeback states.
- Emits raw (unconditioned) reg_write, mem_write, pc_src, flag_write and no_write to the downstream conditional-logic unit, which gates them with the condition check.
- Emits datapath mux selects and enables directly to the datapath.

---
 rtl/ctrl_pkg.sv | 48 ++++
 rtl/alu_decoder.sv | 30 +++
 rtl/multi_cycle_control_fsm.sv | 147 ++++++++++++++
 tb/tb_multi_cycle_control_fsm.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared encodings for the multicycle control unit
// Purpose: state enum, op/cmd encodings, ALU control and datapath mux-select constants.
// Ports: none (package).
package ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADR   = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXEC_R    = 4'd6,
    EXEC_I    = 4'd7,
    ALU_WB    = 4'd8,
    BRANCH    = 4'd9
  } state_t;

  // instruction classes
  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;
  localparam logic [1:0] OP_ILL = 2'b11;

  // data-processing commands
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  // alu_control
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // alu_src_b
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // result_src
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// rtl/alu_decoder.sv - data-processing cmd/S to ALU control and flag request
// Purpose: combinational map shared by the multicycle and single-cycle control units.
// Ports: cmd (funct[4:1]), s (funct[0]) in; alu_control, flag_write, no_write out.
module alu_decoder
  import ctrl_pkg::*;
(
  input  logic [3:0] cmd,
  input  logic       s,
  output logic [1:0] alu_control,
  output logic       flag_write,
  output logic       no_write
);

  always_comb begin
    alu_control = ALU_ADD;
    unique case (cmd)
      CMD_ADD: alu_control = ALU_ADD;
      CMD_SUB: alu_control = ALU_SUB;
      CMD_AND: alu_control = ALU_AND;
      CMD_ORR: alu_control = ALU_ORR;
      CMD_CMP: alu_control = ALU_SUB;
      default: alu_control = ALU_ADD;
    endcase
  end

  // compare always sets flags and never writes its destination
  assign flag_write = s | (cmd == CMD_CMP);
  assign no_write   = (cmd == CMD_CMP);

endmodule

// File: rtl/multi_cycle_control_fsm.sv
// rtl/multi_cycle_control_fsm.sv - multicycle processor main control FSM
// Purpose: sequences each instruction FETCH -> DECODE -> exec/mem/writeback and drives
//   datapath selects plus raw (ungated) write requests to the conditional-logic unit.
// Ports: clk, reset (sync, active-high), op, funct, rd_is_pc, mem_ready in;
//   ir_write, pc_write, pc_src, reg_write, mem_write, flag_write, no_write, adr_src,
//   alu_src_a, alu_src_b, result_src, alu_control, state_o out.
module multi_cycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int OP_W       = 2,
  parameter int FUNCT_W    = 6,
  parameter int ALU_CTRL_W = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [OP_W-1:0]       op,
  input  logic [FUNCT_W-1:0]    funct,
  input  logic                  rd_is_pc,
  input  logic                  mem_ready,
  output logic                  ir_write,
  output logic                  pc_write,
  output logic                  pc_src,
  output logic                  reg_write,
  output logic                  mem_write,
  output logic                  flag_write,
  output logic                  no_write,
  output logic                  adr_src,
  output logic                  alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [1:0]            result_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic [3:0]            state_o
);

  state_t     state;
  state_t     next_state;
  logic [1:0] dec_alu_control;
  logic       dec_flag_write;
  logic       dec_no_write;
  logic [1:0] alu_ctrl_int;

  alu_decoder u_alu_decoder (
    .cmd         (funct[4:1]),
    .s           (funct[0]),
    .alu_control (dec_alu_control),
    .flag_write  (dec_flag_write),
    .no_write    (dec_no_write)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    ir_write     = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 1'b0;
    reg_write    = 1'b0;
    mem_write    = 1'b0;
    flag_write   = 1'b0;
    no_write     = 1'b0;
    adr_src      = 1'b0;
    alu_src_a    = 1'b1;
    alu_src_b    = SRCB_FOUR;
    result_src   = RES_ALU;
    alu_ctrl_int = ALU_ADD;

    unique case (state)
      FETCH: begin
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) next_state = DECODE;
      end
      DECODE: begin
        unique case (op)
          OP_DP:   next_state = funct[5] ? EXEC_I : EXEC_R;
          OP_MEM:  next_state = MEM_ADR;
          OP_BR:   next_state = BRANCH;
          default: next_state = FETCH;
        endcase
      end
      EXEC_R, EXEC_I: begin
        alu_src_a    = 1'b0;
        alu_src_b    = (state == EXEC_I) ? SRCB_IMM : SRCB_REG;
        alu_ctrl_int = dec_alu_control;
        flag_write   = dec_flag_write;
        next_state   = ALU_WB;
      end
      ALU_WB: begin
        result_src = RES_ALUOUT;
        reg_write  = 1'b1;
        no_write   = dec_no_write;
        pc_src     = rd_is_pc;
        next_state = FETCH;
      end
      MEM_ADR: begin
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_IMM;
        next_state = funct[0] ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        adr_src = 1'b1;
        if (mem_ready) next_state = MEM_WB;
      end
      MEM_WB: begin
        result_src = RES_DATA;
        reg_write  = 1'b1;
        pc_src     = rd_is_pc;
        next_state = FETCH;
      end
      MEM_WRITE: begin
        adr_src   = 1'b1;
        mem_write = mem_ready;
        if (mem_ready) next_state = FETCH;
      end
      BRANCH: begin
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_IMM;
        pc_src     = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase

    // reset abandons the instruction in flight: no writes leave this cycle
    if (reset) begin
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = 1'b0;
      reg_write    = 1'b0;
      mem_write    = 1'b0;
      flag_write   = 1'b0;
      no_write     = 1'b0;
      adr_src      = 1'b0;
      alu_src_a    = 1'b1;
      alu_src_b    = SRCB_FOUR;
      result_src   = RES_ALU;
      alu_ctrl_int = ALU_ADD;
    end
  end

  assign alu_control = ALU_CTRL_W'(alu_ctrl_int);
  assign state_o     = state;

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// tb/tb_multi_cycle_control_fsm.sv - directed self-checking bench for multi_cycle_control_fsm
module tb_multi_cycle_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] op;
  logic [5:0] funct;
  logic       rd_is_pc;
  logic       mem_ready;
  logic       ir_write, pc_write, pc_src, reg_write, mem_write, flag_write, no_write;
  logic       adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, alu_control;
  logic [3:0] state_o;
  logic [5:0] en;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  multi_cycle_control_fsm #(.OP_W(2), .FUNCT_W(6), .ALU_CTRL_W(2)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .rd_is_pc(rd_is_pc),
    .mem_ready(mem_ready), .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
    .reg_write(reg_write), .mem_write(mem_write), .flag_write(flag_write),
    .no_write(no_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
    .state_o(state_o)
  );

  assign en = {ir_write, pc_write, pc_src, reg_write, mem_write, flag_write};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock; sample 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // from FETCH with mem_ready=1, count cycles until FETCH again
  task automatic latency(input string tag, input logic [1:0] o, input logic [5:0] f,
                         input int exp);
    int n;
    op = o; funct = f; mem_ready = 1'b1; rd_is_pc = 1'b0;
    #1;
    check({tag, "_start"}, state_o, 0);
    n = 0;
    do begin
      step();
      n++;
    end while (state_o != 4'd0 && n < 20);
    check({tag, "_cycles"}, n, exp);
  endtask

  initial begin
    int n;
    reset = 1'b1; op = 2'b00; funct = 6'b0; rd_is_pc = 1'b0; mem_ready = 1'b1;

    // reset for 2 cycles
    step();
    check("rst_state", state_o, 0);
    check("rst_en", en, 0);
    check("rst_srca", alu_src_a, 1);
    check("rst_srcb", alu_src_b, 2'b10);
    check("rst_res", result_src, 2'b10);
    check("rst_misc", {no_write, adr_src, alu_control}, 0);
    step();
    reset = 1'b0;

    // FETCH stalls without mem_ready
    mem_ready = 1'b0; #1;
    check("fetch_wait_irw", {ir_write, pc_write}, 0);
    step();
    check("fetch_wait_hold", state_o, 0);

    // immediate ADD
    op = 2'b00; funct = 6'b101000; mem_ready = 1'b1; #1;
    check("addi_fetch_en", {ir_write, pc_write, adr_src}, 3'b110);
    step();
    check("addi_decode", state_o, 1);
    check("addi_dec_src", {alu_src_a, alu_src_b, alu_control}, 5'b1_10_00);
    step();
    check("addi_exec_i", state_o, 7);
    check("addi_exec_src", {alu_src_a, alu_src_b, alu_control, flag_write}, 6'b0_01_00_0);
    step();
    check("addi_alu_wb", state_o, 8);
    check("addi_wb_out", {reg_write, no_write, pc_src, result_src}, 5'b1_0_0_00);
    step();
    check("addi_back_fetch", state_o, 0);

    // CMP with S=1
    funct = 6'b010101;
    step(); step();
    check("cmp_exec_r", state_o, 6);
    check("cmp_exec_out", {alu_src_b, alu_control, flag_write}, 5'b00_01_1);
    step();
    check("cmp_wb_out", {reg_write, no_write}, 2'b11);
    step();

    // ORR, S=0, destination PC
    funct = 6'b011000; rd_is_pc = 1'b1;
    step(); step();
    check("orr_exec_out", {alu_control, flag_write}, 3'b11_0);
    step();
    check("orr_wb_pcsrc", {reg_write, no_write, pc_src}, 3'b101);
    step();
    rd_is_pc = 1'b0;

    // load with 3 wait cycles in MEM_READ
    op = 2'b01; funct = 6'b000001;
    n = 0;
    step(); n++;
    check("ld_decode", state_o, 1);
    step(); n++;
    check("ld_mem_adr", state_o, 2);
    check("ld_adr_src", {alu_src_a, alu_src_b, alu_control}, 5'b0_01_00);
    mem_ready = 1'b0;
    step(); n++;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ld_wait%0d", i), {state_o, adr_src, en}, {4'd3, 1'b1, 6'b0});
      if (i < 2) begin step(); n++; end
    end
    mem_ready = 1'b1;
    step(); n++;
    check("ld_mem_wb", {state_o, result_src, reg_write}, {4'd4, 2'b01, 1'b1});
    step(); n++;
    check("ld_total", {state_o, 8'(n)}, {4'd0, 8'd7});

    // store with 2 wait cycles
    funct = 6'b000000;
    step(); step();
    mem_ready = 1'b0;
    step();
    check("st_state", state_o, 5);
    check("st_wait0", {mem_write, adr_src}, 2'b01);
    step();
    check("st_wait1", {state_o, mem_write}, {4'd5, 1'b0});
    mem_ready = 1'b1; #1;
    check("st_pulse", mem_write, 1);
    step();
    check("st_done", {state_o, mem_write}, {4'd0, 1'b0});

    // branch
    op = 2'b10;
    step(); step();
    check("br_state", state_o, 9);
    check("br_out", {pc_src, alu_src_a, alu_src_b, result_src}, 6'b1_0_01_10);
    step();
    check("br_done", state_o, 0);

    // illegal op: DECODE goes straight back to FETCH with no writes
    op = 2'b11;
    step();
    check("ill_decode_en", {state_o, en}, {4'd1, 6'b0});
    step();
    check("ill_done", state_o, 0);

    // latency table with mem_ready high throughout
    latency("lat_dp", 2'b00, 6'b000001, 4);
    latency("lat_ld", 2'b01, 6'b000001, 5);
    latency("lat_st", 2'b01, 6'b000000, 4);
    latency("lat_br", 2'b10, 6'b000000, 3);
    latency("lat_ill", 2'b11, 6'b000000, 2);

    // reset while MEM_WRITE has mem_ready high
    op = 2'b01; funct = 6'b000000; mem_ready = 1'b1;
    step(); step(); step();
    check("rstmw_state", state_o, 5);
    reset = 1'b1; #1;
    check("rstmw_en", en, 0);
    step();
    check("rstmw_fetch", state_o, 0);
    reset = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
